// File: rtl/xgmii_encoder.sv
// xgmii_encoder: 64b/66b transmit PCS encoder (XGMII word pairs -> 66b blocks).
// Define ENCODER_SEQ_CHECK_EN to enable the TX block-sequence checker.

package code_defs_pkg;
    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTL  = 2'b10;

    localparam logic [7:0] BT_IDLE = 8'h1E;
    localparam logic [7:0] BT_O4   = 8'h2D;
    localparam logic [7:0] BT_S4   = 8'h33;
    localparam logic [7:0] BT_O0S4 = 8'h66;
    localparam logic [7:0] BT_O0O4 = 8'h55;
    localparam logic [7:0] BT_S0   = 8'h78;
    localparam logic [7:0] BT_O0   = 8'h4B;
    localparam logic [7:0] BT_T0   = 8'h87;
    localparam logic [7:0] BT_T1   = 8'h99;
    localparam logic [7:0] BT_T2   = 8'hAA;
    localparam logic [7:0] BT_T3   = 8'hB4;
    localparam logic [7:0] BT_T4   = 8'hCC;
    localparam logic [7:0] BT_T5   = 8'hD2;
    localparam logic [7:0] BT_T6   = 8'hE1;
    localparam logic [7:0] BT_T7   = 8'hFF;

    localparam logic [7:0] RS_IDLE  = 8'h07;
    localparam logic [7:0] RS_START = 8'hFB;
    localparam logic [7:0] RS_TERM  = 8'hFD;
    localparam logic [7:0] RS_ERROR = 8'hFE;
    localparam logic [7:0] RS_OS    = 8'h9C;

    localparam logic [6:0] CC_IDLE  = 7'h00;
    localparam logic [6:0] CC_ERROR = 7'h1E;
endpackage

module xgmii_encoder #(
    parameter int DATA_WIDTH = 32,
    localparam int DATA_NBYTES = DATA_WIDTH / 8
) (
    input  logic                   i_txc,
    input  logic                   i_reset,
    input  logic [DATA_WIDTH-1:0]  i_txd,
    input  logic [DATA_NBYTES-1:0] i_txctl,
    input  logic                   i_tx_ready,
    output logic [DATA_WIDTH-1:0]  o_txd,
    output logic [1:0]             o_tx_header,
    output logic                   o_tx_header_valid
);
    import code_defs_pkg::*;

    localparam logic [63:0] ERR_BLK = {{8{CC_ERROR}}, BT_IDLE};

    typedef enum logic [2:0] {
        CL_C, CL_S, CL_D, CL_T, CL_E
    } blk_class_t;

    logic                  phase;
    logic [DATA_WIDTH-1:0] cap_d;
    logic [3:0]            cap_c;
    logic [63:0]           blk;
    logic [1:0]            hdr;
    logic                  blk_vld;

    logic [63:0] blk_d;
    logic [7:0]  blk_c;
    logic [7:0]  l0;
    logic [7:0]  l4;
    logic [55:0] codes;
    logic [7:0]  t_hit;
    logic [2:0]  t_lane;
    logic [63:0] t_pay;
    logic [63:0] enc_pay;
    logic [1:0]  enc_hdr;
    blk_class_t  cls;
    logic        seq_err;
    logic [63:0] blk_nxt;
    logic [1:0]  hdr_nxt;

    logic is_data, is_idle, is_s0, is_s4;
    logic is_o0, is_o4, is_o0o4, is_o0s4;

    assign blk_d = {i_txd, cap_d};
    assign blk_c = {i_txctl, cap_c};
    assign l0    = blk_d[7:0];
    assign l4    = blk_d[39:32];

    assign is_data = (blk_c == 8'h00);
    assign is_idle = (blk_c == 8'hFF) && !t_hit[0];
    assign is_s0   = (blk_c == 8'h01) && (l0 == RS_START);
    assign is_s4   = (blk_c == 8'h1F) && (l4 == RS_START);
    assign is_o4   = (blk_c == 8'h1F) && (l4 == RS_OS);
    assign is_o0   = (blk_c == 8'hF1) && (l0 == RS_OS);
    assign is_o0o4 = (blk_c == 8'h11) && (l0 == RS_OS)
                   && (l4 == RS_OS);
    assign is_o0s4 = (blk_c == 8'h11) && (l0 == RS_OS)
                   && (l4 == RS_START);

    function automatic logic [7:0] bt_term(input logic [2:0] n);
        logic [7:0] bt;
        case (n)
            3'd0:    bt = BT_T0;
            3'd1:    bt = BT_T1;
            3'd2:    bt = BT_T2;
            3'd3:    bt = BT_T3;
            3'd4:    bt = BT_T4;
            3'd5:    bt = BT_T5;
            3'd6:    bt = BT_T6;
            default: bt = BT_T7;
        endcase
        return bt;
    endfunction

    // per-lane 7-bit control codes and terminate-lane detection
    always_comb begin
        codes  = '0;
        t_hit  = '0;
        t_lane = '0;
        for (int n = 0; n < 8; n++) begin
            codes[7*n +: 7] = (blk_d[8*n +: 8] == RS_IDLE)
                            ? CC_IDLE : CC_ERROR;
            t_hit[n] = (blk_d[8*n +: 8] == RS_TERM)
                     && (blk_c == (8'hFF << n));
            if (t_hit[n]) t_lane = 3'(n);
        end
    end

    // terminate payload: leading data, zero pad, trailing codes
    always_comb begin
        t_pay = {codes, 8'h00};
        for (int b = 8; b < 64; b++) begin
            if (b <= 7 * int'(t_lane) + 14) t_pay[b] = 1'b0;
        end
        for (int j = 0; j < 7; j++) begin
            if (j < int'(t_lane))
                t_pay[8 + 8*j +: 8] = blk_d[8*j +: 8];
        end
        t_pay[7:0] = bt_term(t_lane);
    end

    // block-type decode; undecodable patterns fall to the error block
    always_comb begin
        enc_hdr = SYNC_CTL;
        enc_pay = ERR_BLK;
        cls     = CL_E;
        unique case (1'b1)
            is_data: begin
                enc_hdr = SYNC_DATA;
                enc_pay = blk_d;
                cls     = CL_D;
            end
            is_idle: begin
                enc_pay = {codes, BT_IDLE};
                cls     = CL_C;
            end
            (|t_hit): begin
                enc_pay = t_pay;
                cls     = CL_T;
            end
            is_s0: begin
                enc_pay = {blk_d[63:8], BT_S0};
                cls     = CL_S;
            end
            is_s4: begin
                enc_pay = {blk_d[63:40], 4'h0,
                           codes[27:0], BT_S4};
                cls     = CL_S;
            end
            is_o4: begin
                enc_pay = {blk_d[63:40], 4'h0,
                           codes[27:0], BT_O4};
                cls     = CL_C;
            end
            is_o0: begin
                enc_pay = {codes[55:28], 4'h0,
                           blk_d[31:8], BT_O0};
                cls     = CL_C;
            end
            is_o0o4: begin
                enc_pay = {blk_d[63:40], 8'h00,
                           blk_d[31:8], BT_O0O4};
                cls     = CL_C;
            end
            is_o0s4: begin
                enc_pay = {blk_d[63:40], 8'h00,
                           blk_d[31:8], BT_O0S4};
                cls     = CL_S;
            end
            default: ;
        endcase
    end

`ifdef ENCODER_SEQ_CHECK_EN
    typedef enum logic [2:0] {
        TX_INIT, TX_C, TX_D, TX_T, TX_E
    } tx_state_t;

    tx_state_t state;
    tx_state_t state_nxt;

    // sequence state advances once per encoded block
    always_ff @(posedge i_txc) begin
        if (i_reset)
            state <= TX_INIT;
        else if (i_tx_ready && phase)
            state <= state_nxt;
    end

    // legal-transition check; illegal blocks become error blocks
    always_comb begin
        state_nxt = state;
        seq_err   = 1'b0;
        case (state)
            TX_D: begin
                case (cls)
                    CL_D:    state_nxt = TX_D;
                    CL_T:    state_nxt = TX_T;
                    default: begin
                        state_nxt = TX_E;
                        seq_err   = 1'b1;
                    end
                endcase
            end
            TX_E: begin
                case (cls)
                    CL_C:    state_nxt = TX_C;
                    CL_S:    state_nxt = TX_D;
                    CL_D:    state_nxt = TX_D;
                    CL_T:    state_nxt = TX_T;
                    default: state_nxt = TX_E;
                endcase
            end
            default: begin
                case (cls)
                    CL_C:    state_nxt = TX_C;
                    CL_S:    state_nxt = TX_D;
                    default: begin
                        state_nxt = TX_E;
                        seq_err   = 1'b1;
                    end
                endcase
            end
        endcase
    end
`else
    logic unused_cls;
    assign unused_cls = ^cls;
    assign seq_err    = 1'b0;
`endif

    assign blk_nxt = seq_err ? ERR_BLK  : enc_pay;
    assign hdr_nxt = seq_err ? SYNC_CTL : enc_hdr;

    // phase 0 captures lanes 0-3 and emits the lower half;
    // phase 1 registers the block and emits the upper half
    always_ff @(posedge i_txc) begin
        if (i_reset) begin
            phase             <= 1'b0;
            cap_d             <= '0;
            cap_c             <= '0;
            blk               <= '0;
            hdr               <= 2'b00;
            blk_vld           <= 1'b0;
            o_txd             <= '0;
            o_tx_header       <= 2'b00;
            o_tx_header_valid <= 1'b0;
        end else if (i_tx_ready) begin
            phase <= ~phase;
            if (!phase) begin
                cap_d             <= i_txd;
                cap_c             <= i_txctl;
                o_txd             <= blk_vld ? blk[31:0] : '0;
                o_tx_header       <= blk_vld ? hdr : 2'b00;
                o_tx_header_valid <= blk_vld;
            end else begin
                blk               <= blk_nxt;
                hdr               <= hdr_nxt;
                blk_vld           <= 1'b1;
                o_txd             <= blk_vld ? blk[63:32] : '0;
                o_tx_header_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_xgmii_encoder.sv
// tb_xgmii_encoder: directed and random stimulus for xgmii_encoder,
// checked against a bit-append reference encoder and output queue.

module tb_xgmii_encoder;
    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_tx_ready;
    logic [31:0] i_txd;
    logic [3:0]  i_txctl;
    logic [31:0] o_txd;
    logic [1:0]  o_tx_header;
    logic        o_tx_header_valid;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    xgmii_encoder dut (
        .i_txc             (clk),
        .i_reset           (i_reset),
        .i_txd             (i_txd),
        .i_txctl           (i_txctl),
        .i_tx_ready        (i_tx_ready),
        .o_txd             (o_txd),
        .o_tx_header       (o_tx_header),
        .o_tx_header_valid (o_tx_header_valid)
    );

    localparam int K_C = 0, K_S = 1, K_D = 2, K_T = 3, K_E = 4;
    localparam int S_INIT = 0, S_C = 1, S_D = 2, S_T = 3, S_E = 4;

    localparam logic [71:0] IDLE_BLK =
        {8'hFF, 64'h07070707_07070707};
    localparam logic [71:0] S0_BLK =
        {8'h01, 64'hD5555555_555555FB};
    localparam logic [71:0] DATA_BLK =
        {8'h00, 64'h01234567_89ABCDEF};
    localparam logic [71:0] T3_BLK =
        {8'hF8, 64'h07070707_FDAABBCC};

    typedef struct {
        logic [1:0]  h;
        logic [63:0] p;
        int          cls;
    } enc_t;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  h;
        logic        v;
    } half_t;

    half_t       q[$];
    logic [31:0] exp_d;
    logic [1:0]  exp_h;
    logic        exp_v;
    logic        chk_h;
    int          ph;
    logic [31:0] m_cap_d;
    logic [3:0]  m_cap_c;
    int          st;
    int          pause_pct;

    function automatic void app(inout logic [63:0] p,
                                inout int pos,
                                input logic [7:0] v,
                                input int w);
        for (int i = 0; i < w; i++) p[pos + i] = v[i];
        pos += w;
    endfunction

    function automatic logic [7:0] code7(input logic [7:0] b);
        return (b == 8'h07) ? 8'h00 : 8'h1E;
    endfunction

    function automatic enc_t err_block();
        enc_t r;
        logic [63:0] pay;
        int pos;
        pay = '0;
        pos = 0;
        app(pay, pos, 8'h1E, 8);
        for (int k = 0; k < 8; k++) app(pay, pos, 8'h1E, 7);
        r.h = 2'b10;
        r.p = pay;
        r.cls = K_E;
        return r;
    endfunction

    function automatic enc_t model_enc(input logic [63:0] d,
                                       input logic [7:0] c);
        enc_t r;
        logic [63:0] pay;
        int pos;
        int p;
        logic [7:0] b [8];
        logic [7:0] bt_t [8];
        bt_t = '{8'h87, 8'h99, 8'hAA, 8'hB4,
                 8'hCC, 8'hD2, 8'hE1, 8'hFF};
        pay = '0;
        pos = 0;
        p = 0;
        r.h = 2'b10;
        r.p = '0;
        r.cls = K_E;
        for (int i = 0; i < 8; i++) b[i] = d[8*i +: 8];
        for (int i = 7; i >= 0; i--) if (c[i]) p = i;
        if (c == 8'h00) begin
            r.h = 2'b01;
            r.p = d;
            r.cls = K_D;
            return r;
        end
        if (b[p] == 8'hFD && (c >> p) == (8'hFF >> p)) begin
            app(pay, pos, bt_t[p], 8);
            for (int j = 0; j < p; j++) app(pay, pos, b[j], 8);
            app(pay, pos, 8'h00, 7 - p);
            for (int k = p + 1; k < 8; k++)
                app(pay, pos, code7(b[k]), 7);
            r.cls = K_T;
        end else if (c == 8'h01 && b[0] == 8'hFB) begin
            app(pay, pos, 8'h78, 8);
            for (int j = 1; j < 8; j++) app(pay, pos, b[j], 8);
            r.cls = K_S;
        end else if (c == 8'h1F &&
                     (b[4] == 8'hFB || b[4] == 8'h9C)) begin
            app(pay, pos, (b[4] == 8'hFB) ? 8'h33 : 8'h2D, 8);
            for (int k = 0; k < 4; k++)
                app(pay, pos, code7(b[k]), 7);
            app(pay, pos, 8'h00, 4);
            for (int j = 5; j < 8; j++) app(pay, pos, b[j], 8);
            r.cls = (b[4] == 8'hFB) ? K_S : K_C;
        end else if (c == 8'hF1 && b[0] == 8'h9C) begin
            app(pay, pos, 8'h4B, 8);
            for (int j = 1; j < 4; j++) app(pay, pos, b[j], 8);
            app(pay, pos, 8'h00, 4);
            for (int k = 4; k < 8; k++)
                app(pay, pos, code7(b[k]), 7);
            r.cls = K_C;
        end else if (c == 8'h11 && b[0] == 8'h9C &&
                     (b[4] == 8'h9C || b[4] == 8'hFB)) begin
            app(pay, pos, (b[4] == 8'h9C) ? 8'h55 : 8'h66, 8);
            for (int j = 1; j < 4; j++) app(pay, pos, b[j], 8);
            app(pay, pos, 8'h00, 8);
            for (int j = 5; j < 8; j++) app(pay, pos, b[j], 8);
            r.cls = (b[4] == 8'h9C) ? K_C : K_S;
        end else if (c == 8'hFF) begin
            app(pay, pos, 8'h1E, 8);
            for (int k = 0; k < 8; k++)
                app(pay, pos, code7(b[k]), 7);
            r.cls = K_C;
        end else begin
            return err_block();
        end
        r.p = pay;
        return r;
    endfunction

    function automatic enc_t seq_apply(input enc_t e);
`ifdef ENCODER_SEQ_CHECK_EN
        bit ok;
        if (st == S_D)
            ok = (e.cls == K_D || e.cls == K_T);
        else if (st == S_E)
            ok = 1'b1;
        else
            ok = (e.cls == K_C || e.cls == K_S);
        if (!ok) begin
            st = S_E;
            return err_block();
        end
        case (e.cls)
            K_C:     st = S_C;
            K_S:     st = S_D;
            K_D:     st = S_D;
            K_T:     st = S_T;
            default: st = S_E;
        endcase
`endif
        return e;
    endfunction

    task automatic model_step(input logic [31:0] d,
                              input logic [3:0] c,
                              input logic rdy,
                              input logic rst);
        half_t hf;
        enc_t e;
        chk_h = 1'b0;
        if (rst) begin
            q.delete();
            ph = 0;
            m_cap_d = '0;
            m_cap_c = '0;
            st = S_INIT;
            exp_d = '0;
            exp_h = 2'b00;
            exp_v = 1'b0;
            chk_h = 1'b1;
        end else if (rdy) begin
            if (q.size() > 0) begin
                hf = q.pop_front();
                exp_d = hf.d;
                exp_v = hf.v;
                exp_h = hf.h;
                chk_h = hf.v;
            end else begin
                exp_d = '0;
                exp_v = 1'b0;
            end
            if (ph == 0) begin
                m_cap_d = d;
                m_cap_c = c;
            end else begin
                e = model_enc({d, m_cap_d}, {c, m_cap_c});
                e = seq_apply(e);
                hf.d = e.p[31:0];
                hf.h = e.h;
                hf.v = 1'b1;
                q.push_back(hf);
                hf.d = e.p[63:32];
                hf.v = 1'b0;
                q.push_back(hf);
            end
            ph ^= 1;
        end else begin
            chk_h = exp_v;
        end
    endtask

    task automatic check();
        vectors++;
        assert (o_txd === exp_d) else begin
            miscompares++;
            $error("FAIL o_txd obs=%h exp=%h t=%0t",
                   o_txd, exp_d, $time);
        end
        vectors++;
        assert (o_tx_header_valid === exp_v) else begin
            miscompares++;
            $error("FAIL hdr_valid obs=%b exp=%b t=%0t",
                   o_tx_header_valid, exp_v, $time);
        end
        if (chk_h) begin
            vectors++;
            assert (o_tx_header === exp_h) else begin
                miscompares++;
                $error("FAIL header obs=%b exp=%b t=%0t",
                       o_tx_header, exp_h, $time);
            end
        end
    endtask

    task automatic cyc(input logic [31:0] d,
                       input logic [3:0] c,
                       input logic rdy,
                       input logic rst);
        i_txd      = d;
        i_txctl    = c;
        i_tx_ready = rdy;
        i_reset    = rst;
        @(posedge clk);
        #1;
        model_step(d, c, rdy, rst);
        check();
    endtask

    task automatic word(input logic [31:0] d,
                        input logic [3:0] c);
        while ($urandom_range(0, 99) < pause_pct)
            cyc($urandom, 4'($urandom), 1'b0, 1'b0);
        cyc(d, c, 1'b1, 1'b0);
    endtask

    task automatic pair(input logic [71:0] blk);
        word(blk[31:0], blk[67:64]);
        word(blk[63:32], blk[71:68]);
    endtask

    function automatic logic [71:0] rnd_block();
        logic [63:0] d;
        logic [7:0] c;
        logic [7:0] pick [4];
        int p;
        pick = '{8'h07, 8'hFE, 8'h9C, 8'hFB};
        d = {$urandom, $urandom};
        c = 8'h00;
        case ($urandom_range(0, 11))
            0, 1, 11: begin
                d = {8{8'h07}};
                c = 8'hFF;
            end
            2: begin
                d[7:0] = 8'hFB;
                c = 8'h01;
            end
            3, 4, 5: c = 8'h00;
            6: begin
                p = $urandom_range(0, 7);
                for (int i = 0; i < 8; i++) begin
                    if (i > p) begin
                        c[i] = 1'b1;
                        d[8*i +: 8] = ($urandom_range(0, 3) == 0)
                                    ? 8'hFE : 8'h07;
                    end
                end
                c[p] = 1'b1;
                d[8*p +: 8] = 8'hFD;
            end
            7: begin
                d[39:0] = {8'hFB, {4{8'h07}}};
                c = 8'h1F;
            end
            8: begin
                case ($urandom_range(0, 3))
                    0: begin
                        d[63:32] = {4{8'h07}};
                        d[7:0] = 8'h9C;
                        c = 8'hF1;
                    end
                    1: begin
                        d[39:0] = {8'h9C, {4{8'h07}}};
                        c = 8'h1F;
                    end
                    2: begin
                        d[7:0] = 8'h9C;
                        d[39:32] = 8'h9C;
                        c = 8'h11;
                    end
                    default: begin
                        d[7:0] = 8'h9C;
                        d[39:32] = 8'hFB;
                        c = 8'h11;
                    end
                endcase
            end
            9: begin
                c = 8'hFF;
                for (int i = 0; i < 8; i++)
                    d[8*i +: 8] = pick[$urandom_range(0, 3)];
            end
            default: c = 8'($urandom);
        endcase
        return {c, d};
    endfunction

    initial begin
        i_reset    = 1'b1;
        i_tx_ready = 1'b0;
        i_txd      = '0;
        i_txctl    = '0;
        pause_pct  = 0;
        st         = S_INIT;
        ph         = 0;
        exp_d      = '0;
        exp_h      = 2'b00;
        exp_v      = 1'b0;
        chk_h      = 1'b0;
        m_cap_d    = '0;
        m_cap_c    = '0;

        cyc(32'hFFFFFFFF, 4'hF, 1'b1, 1'b1);
        cyc(32'h0, 4'h0, 1'b0, 1'b1);

        repeat (4) pair(IDLE_BLK);
        pair(S0_BLK);
        pair(DATA_BLK);
        pair(T3_BLK);
        pair(IDLE_BLK);

        word(S0_BLK[31:0], S0_BLK[67:64]);
        repeat (3) cyc($urandom, 4'($urandom), 1'b0, 1'b0);
        word(S0_BLK[63:32], S0_BLK[71:68]);
        pair(DATA_BLK);
        pair(T3_BLK);
        pair(IDLE_BLK);

        pair(IDLE_BLK);
        pair(DATA_BLK);
        pair(S0_BLK);
        pair(DATA_BLK);
        pair(T3_BLK);
        pair(IDLE_BLK);

        word(S0_BLK[31:0], S0_BLK[67:64]);
        cyc(32'h12345678, 4'h0, 1'b1, 1'b1);
        pair(IDLE_BLK);
        pair(S0_BLK);
        pair(T3_BLK);
        pair(IDLE_BLK);

        pause_pct = 25;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 199) == 0)
                cyc($urandom, 4'($urandom), 1'($urandom), 1'b1);
            pair(rnd_block());
        end
        pause_pct = 0;
        repeat (3) pair(IDLE_BLK);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/xgmii_encoder.md
# xgmii_encoder

Transmit-side 64b/66b PCS encoder. Accepts 32-bit XGMII data/control words from the MAC, pairs consecutive words into a 64-bit XGMII block, encodes it to a 2-bit sync header plus 64-bit payload, and presents the result as two 32-bit halves to the scrambler/gearbox. It is the transmit counterpart of the PCS receive decoder and uses the same `code_defs_pkg` constants.

## Interface
- `DATA_WIDTH`, 32, word width; fixed.
- `DATA_NBYTES`, `DATA_WIDTH/8`, control bits per word; fixed.

- `i_txc`  in  1  transmit clock; all logic on the rising edge.
- `i_reset`  in  1  reset; synchronous, active-high.
- `i_txd`  in  32  XGMII data; byte 0 in [7:0].
- `i_txctl`  in  4  XGMII control flags; bit n qualifies byte n.
- `i_tx_ready`  in  1  gearbox accept; low means a pause cycle: no input consumed, no output change.
- `o_txd`  out  32  encoded payload half; lower half first.
- `o_tx_header`  out  2  sync header; meaningful only with `o_tx_header_valid`.
- `o_tx_header_valid`  out  1  high on the lower-half cycle of each block.

## Operation
- Phase bit toggles on every `i_tx_ready` cycle. Phase 0 captures `i_txd`/`i_txctl` as lanes 0-3. Phase 1 combines them with the current word as lanes 4-7 and encodes the 64-bit block.
- Header: all `i_txctl` bits zero -> `SYNC_DATA` and payload = data. Otherwise -> `SYNC_CTL`, and the payload is the block-type byte plus the fields below.
- Mapping is the inverse of the receive decoder:
  - All control -> `BT_IDLE`, 7-bit codes (`RS_IDLE` -> 7'h00, `RS_ERROR`/other -> 7'h1E).
  - `RS_START` in lane 0 with lanes 1-7 data -> `BT_S0`.
  - Lanes 0-3 control and `RS_START` in lane 4 -> `BT_S4`.
  - Sequence ordered set (0x9C) in lane 0 and/or lane 4 -> `BT_O0`, `BT_O4`, `BT_O0O4`, `BT_O0S4`, with O-code nibble 0x0.
  - `RS_TERM` in lane n preceded by data only and followed by control only -> `BT_T0`..`BT_T7`, with 7-bit codes for the trailing lanes.
  - Any other pattern -> error block: `SYNC_CTL`, `BT_IDLE`, eight 7'h1E codes.
- Encoded block is registered. The next `i_tx_ready` cycle drives payload[31:0] with the header and `o_tx_header_valid`=1. The following one drives payload[63:32] with `o_tx_header_valid`=0.
- Sequence check (see Configuration) classifies each block as C, S, D, T or E. States TX_INIT, TX_C, TX_D, TX_T, TX_E:
  - TX_INIT, TX_C, TX_T: C->TX_C, S->TX_D, else error -> TX_E.
  - TX_D: D->TX_D, T->TX_T, else error -> TX_E.
  - TX_E: C->TX_C, S->TX_D, D->TX_D, T->TX_T, E->TX_E.
  - In an error transition the error block replaces the encoded block.

## Timing
- Reset values: `o_txd`=0, `o_tx_header`=2'b00, `o_tx_header_valid`=0, phase 0, state TX_INIT, capture register 0.
- Latency: word pair consumed on ready cycles k, k+1; lower half appears after ready cycle k+2, upper half after k+3.
- `i_tx_ready` low: all registers hold, including phase, state and outputs. Pause cycles are transparent.
- Reset mid-block discards any half-captured pair. The first post-reset output comes from the first pair consumed after reset.
- Reset and `i_tx_ready` asserted together: reset wins.

## Configuration
- `ENCODER_SEQ_CHECK_EN` defined: TX_* state machine active; illegal transitions emit error blocks.
- Undefined: no state machine; every block is encoded independently. Only undecodable patterns produce error blocks.

## Test plan
- Idle: 0x07070707/ctl 0xF repeated -> header 2'b10, payload 0x00000000_0000001E, `o_tx_header_valid` alternating 1,0.
- Start+data: {0x555555FB ctl 0x1, 0xD5555555 ctl 0x0} -> header 2'b10, payload 0xD5555555_55555578; then all-data pair -> header 2'b01, payload = data.
- Terminate: lanes 0-2 data 0xAABBCC, lane 3 `RS_TERM`, lanes 4-7 idle -> `BT_T3` (0xB4), bytes 1-3 = 0xCC,0xBB,0xAA, trailing codes 0.
- Pause: `i_tx_ready` low 3 cycles mid-pair -> outputs frozen; encoding identical to the unpaused run.
- Sequence (macro on): C block then D block -> error block (BT 0x1E, codes 7'h1E), state TX_E; next S block -> normal S0 encoding. Macro off: D encoded as data.
- Reset between first and second word -> outputs 0; next pair encodes from a fresh phase 0.
